dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Blocking miss controller that sequences the 4-way data cache array for the LSQ.
- Serves one load port and one retired-store port with valid/ready handshakes. Reads and writes hits in the array; on a miss it writes back a dirty victim, fetches the line over the tagged memory bus, installs it, then retries the pending request.
- One miss outstanding at a time. Write-allocate, write-back.

Parameters:
- MEM_TAG_W, 4, width of the memory transaction tag; tag 0 means "not accepted / no response".
- CNT_W, 32, width of the performance counters.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ld_req_valid  in  1  load request pending; held until accepted
- ld_req_addr  in  64 (SASS_ADDR)  load address
- ld_req_ready  out  1  load accepted this cycle
- ld_rsp_valid  out  1  load data valid (one-cycle pulse)
- ld_rsp_data  out  64  load data
- st_req_valid  in  1  retired store pending; held until accepted
- st_req_addr  in  64 (SASS_ADDR)  store address
- st_req_data  in  64  store data (full 8-byte line)
- st_req_ready  out  1  store accepted this cycle
- rd1_addr, rd1_search  out  64, 1  array read port
- rd1_hit_out, rd1_data_out  in  1, 64  array read result
- wr1_addr, wr1_search, wr1_en, wr1_from_mem, wr1_data, wr1_dirty, wr1_valid  out  64, 1, 1, 1, 64, 1, 1  array write port
- wr1_hit_out  in  1  array write-port hit
- evicted_valid_out, evicted_dirty_out, evicted_addr_out, evicted_data_out  in  1, 1, 64, 64  LRU victim for the wr1_addr set
- proc2mem_command  out  2  BUS_NONE / BUS_LOAD / BUS_STORE
- proc2mem_addr  out  64  line-aligned address (bits [2:0] = 0)
- proc2mem_data  out  64  writeback data
- mem2proc_response  in  MEM_TAG_W  nonzero = request accepted with this tag
- mem2proc_tag  in  MEM_TAG_W  tag of the returning data
- mem2proc_data  in  64  fill data
- miss_count, wb_count  out  CNT_W  saturating performance counters

Behaviour:
- Reset (async, active-high): state IDLE. All handshake outputs 0, proc2mem_command = BUS_NONE, wr1_en = 0, latched tag = 0, counters = 0, ld_rsp_data = 0. Any in-flight memory transaction is abandoned; its late tag cannot match because tag 0 never matches.
- States: IDLE, WB_REQ, FILL_REQ, FILL_WAIT, FILL_WRITE.
- IDLE, read port:
  - rd1_addr = ld_req_addr; rd1_search = ld_req_valid.
  - Load hit: ld_req_ready = 1; the next cycle gives ld_rsp_valid = 1 and ld_rsp_data = registered rd1_data_out.
- IDLE, write port:
  - wr1_addr = st_req_addr; wr1_search = st_req_valid.
  - Store hit: wr1_en = 1, wr1_dirty = 1, wr1_valid = 1, wr1_from_mem = 0, st_req_ready = 1, all in the same cycle.
- Load hit and store hit in the same cycle:
  - Different line addresses ([63:3]): both are accepted.
  - Same line address: only the store is accepted; the load stalls one cycle so that it reads the stored data.
- Miss selection: a store miss has priority over a load miss. A load hit may be accepted in the same cycle a store miss is latched.
- On a miss:
  - Drive wr1_addr = miss address and wr1_search = 1.
  - Latch the miss address, the requester (LD/ST), and evicted_*. Increment miss_count.
  - If evicted_valid_out & evicted_dirty_out, go to WB_REQ; otherwise go to FILL_REQ.
- WB_REQ: drive BUS_STORE with the latched victim address and data until mem2proc_response != 0. On acceptance increment wb_count and go to FILL_REQ.
- FILL_REQ: drive BUS_LOAD with the line-aligned miss address until mem2proc_response != 0. On acceptance latch the response as the tag and go to FILL_WAIT.
- FILL_WAIT:
  - proc2mem_command = BUS_NONE.
  - mem2proc_tag is compared only in this state.
  - When mem2proc_tag == latched tag (and is nonzero), latch mem2proc_data and go to FILL_WRITE.
- FILL_WRITE:
  - Drive wr1_addr = miss address, wr1_en = 1, wr1_from_mem = 1, wr1_valid = 1, wr1_dirty = 0, wr1_data = fill data.
  - Return to IDLE. The original request is still held and is retried there as a hit; its ready is asserted no earlier than one cycle after FILL_WRITE.
- No ready is asserted outside IDLE. ld_rsp_valid never asserts without a prior ld_req_ready.
- Requester contract: valid and address are held stable until ready. Dropping valid mid-miss is legal; the fill still completes and the controller returns to IDLE.
- Counters saturate at all-ones and never wrap.
- Memory rejection (response = 0) is repeated indefinitely with the command held and no timeout.

Test Plan:
- Reset mid-FILL_WAIT (latched tag = 3), then drive mem2proc_tag = 3 -> no wr1_en, state IDLE, miss_count = 0.
- Load miss to 0x1000, clean victim, memory accepts with response = 5, tag 5 returns data 0xAAAA -> BUS_LOAD at 0x1000, one FILL_WRITE with wr1_from_mem = 1, then ld_rsp_data = 0xAAAA; miss_count = 1, wb_count = 0.
- Store miss to 0x2008 with a dirty valid victim (addr 0x3008, data 0x55) -> BUS_STORE at 0x3008 with data 0x55 before BUS_LOAD at 0x2008. After the fill, the store hit writes dirty = 1 with st_req_data. wb_count = 1.
- Same-cycle load hit and store hit to line 0x40 (store data 0x77) -> st_req_ready in cycle N, ld_req_ready in cycle N+1, ld_rsp_data = 0x77.
- Memory returns response = 0 for 3 cycles, then 2 -> BUS_LOAD held for 4 cycles; fill occurs only when tag 2 returns, and an interleaved tag 1 is ignored.
- miss_count preset near saturation (CNT_W = 4, 15 misses, then one more) -> reads 15 and holds there.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// ============================================================================
// Module      : dcache_ctrl_if
// Description : Bundle of every signal between the data-cache miss controller
//               and its neighbours: the LSQ load/store ports, the 4-way data
//               array read/write ports, the victim lookup and the tagged
//               memory bus, plus the performance counters.
//               modport master : the controller (dcache_ctrl)
//               modport slave  : the environment (LSQ, array, memory)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dcache_ctrl_if #(
  parameter int MEM_TAG_W = 4,
  parameter int CNT_W     = 32
) ();
  // LSQ load port
  logic                 ld_req_valid;
  logic [63:0]          ld_req_addr;
  logic                 ld_req_ready;
  logic                 ld_rsp_valid;
  logic [63:0]          ld_rsp_data;
  // LSQ retired-store port
  logic                 st_req_valid;
  logic [63:0]          st_req_addr;
  logic [63:0]          st_req_data;
  logic                 st_req_ready;
  // Data array read port
  logic [63:0]          rd1_addr;
  logic                 rd1_search;
  logic                 rd1_hit_out;
  logic [63:0]          rd1_data_out;
  // Data array write port
  logic [63:0]          wr1_addr;
  logic                 wr1_search;
  logic                 wr1_en;
  logic                 wr1_from_mem;
  logic [63:0]          wr1_data;
  logic                 wr1_dirty;
  logic                 wr1_valid;
  logic                 wr1_hit_out;
  // LRU victim of the set addressed by wr1_addr
  logic                 evicted_valid_out;
  logic                 evicted_dirty_out;
  logic [63:0]          evicted_addr_out;
  logic [63:0]          evicted_data_out;
  // Memory bus
  logic [1:0]           proc2mem_command;
  logic [63:0]          proc2mem_addr;
  logic [63:0]          proc2mem_data;
  logic [MEM_TAG_W-1:0] mem2proc_response;
  logic [MEM_TAG_W-1:0] mem2proc_tag;
  logic [63:0]          mem2proc_data;
  // Performance counters
  logic [CNT_W-1:0]     miss_count;
  logic [CNT_W-1:0]     wb_count;

  modport master (
    input  ld_req_valid, ld_req_addr,
    output ld_req_ready, ld_rsp_valid, ld_rsp_data,
    input  st_req_valid, st_req_addr, st_req_data,
    output st_req_ready,
    output rd1_addr, rd1_search,
    input  rd1_hit_out, rd1_data_out,
    output wr1_addr, wr1_search, wr1_en, wr1_from_mem, wr1_data, wr1_dirty, wr1_valid,
    input  wr1_hit_out,
    input  evicted_valid_out, evicted_dirty_out, evicted_addr_out, evicted_data_out,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_tag, mem2proc_data,
    output miss_count, wb_count
  );

  modport slave (
    output ld_req_valid, ld_req_addr,
    input  ld_req_ready, ld_rsp_valid, ld_rsp_data,
    output st_req_valid, st_req_addr, st_req_data,
    input  st_req_ready,
    input  rd1_addr, rd1_search,
    output rd1_hit_out, rd1_data_out,
    input  wr1_addr, wr1_search, wr1_en, wr1_from_mem, wr1_data, wr1_dirty, wr1_valid,
    output wr1_hit_out,
    output evicted_valid_out, evicted_dirty_out, evicted_addr_out, evicted_data_out,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_tag, mem2proc_data,
    input  miss_count, wb_count
  );
endinterface

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// Module      : dcache_ctrl
// Description : Blocking miss controller for the 4-way write-back,
//               write-allocate data cache. Serves hits from the LSQ load and
//               store ports directly against the array; on a miss it writes
//               back a dirty victim, fetches the line over the tagged memory
//               bus, installs it and lets the held request retry as a hit.
//               Ports:
//                 clock, reset : system clock, async active-high reset
//                 bus          : dcache_ctrl_if.master (LSQ, array, memory,
//                                performance counters)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_ctrl #(
  parameter int MEM_TAG_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic          clock,
  input  logic          reset,
  dcache_ctrl_if.master bus
);

  localparam logic [1:0] c_BUS_NONE  = 2'd0;
  localparam logic [1:0] c_BUS_LOAD  = 2'd1;
  localparam logic [1:0] c_BUS_STORE = 2'd2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WB_REQ     = 3'd1,
    FILL_REQ   = 3'd2,
    FILL_WAIT  = 3'd3,
    FILL_WRITE = 3'd4
  } state_t;

  state_t               r_state;
  logic [63:0]          r_miss_addr;
  logic [63:0]          r_fill_data;
  logic [MEM_TAG_W-1:0] r_tag;
  logic [1:0]           r_cmd;
  logic [63:0]          r_mem_addr;
  logic [63:0]          r_mem_data;
  logic                 r_ld_rsp_valid;
  logic [63:0]          r_ld_rsp_data;
  logic [CNT_W-1:0]     r_miss_count;
  logic [CNT_W-1:0]     r_wb_count;

  logic                 w_idle;
  logic                 w_same_line;
  logic                 w_st_accept;
  logic                 w_ld_accept;
  logic                 w_st_miss;
  logic                 w_ld_miss;
  logic                 w_miss;
  logic [63:0]          w_miss_addr;
  logic                 w_tag_match;

  function automatic logic [63:0] line_align(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

  assign w_idle      = (r_state == IDLE);
  assign w_same_line = (bus.ld_req_addr[63:3] == bus.st_req_addr[63:3]);

  // The write port looks at the store address whenever a store is pending,
  // so wr1_hit_out is only meaningful for the store in that case.
  assign w_st_accept = w_idle & bus.st_req_valid & bus.wr1_hit_out;
  assign w_st_miss   = w_idle & bus.st_req_valid & ~bus.wr1_hit_out;

  // A same-line load behind an accepted store waits one cycle so the array
  // read returns the freshly stored data.
  assign w_ld_accept = w_idle & bus.ld_req_valid & bus.rd1_hit_out &
                       ~(w_st_accept & w_same_line);

  // A load miss is only serviced when no store is pending: the write port
  // (and thus the victim lookup) must point at the load's set.
  assign w_ld_miss   = w_idle & ~bus.st_req_valid & bus.ld_req_valid & ~bus.rd1_hit_out;
  assign w_miss      = w_st_miss | w_ld_miss;
  assign w_miss_addr = bus.st_req_valid ? bus.st_req_addr : bus.ld_req_addr;

  // A latched tag of 0 never matches, so a stale response after reset is ignored.
  assign w_tag_match = (r_tag != '0) && (bus.mem2proc_tag == r_tag);

  // Array port steering
  always_comb begin
    bus.rd1_addr     = bus.ld_req_addr;
    bus.rd1_search   = w_idle & bus.ld_req_valid;
    bus.wr1_addr     = w_miss_addr;
    bus.wr1_search   = w_idle & (bus.st_req_valid | w_ld_miss);
    bus.wr1_en       = w_st_accept;
    bus.wr1_from_mem = 1'b0;
    bus.wr1_data     = bus.st_req_data;
    bus.wr1_dirty    = w_st_accept;
    bus.wr1_valid    = w_st_accept;
    if (r_state == FILL_WRITE) begin
      bus.wr1_addr     = r_miss_addr;
      bus.wr1_search   = 1'b1;
      bus.wr1_en       = 1'b1;
      bus.wr1_from_mem = 1'b1;
      bus.wr1_data     = r_fill_data;
      bus.wr1_dirty    = 1'b0;
      bus.wr1_valid    = 1'b1;
    end
  end

  assign bus.ld_req_ready     = w_ld_accept;
  assign bus.st_req_ready     = w_st_accept;
  assign bus.ld_rsp_valid     = r_ld_rsp_valid;
  assign bus.ld_rsp_data      = r_ld_rsp_data;
  assign bus.proc2mem_command = r_cmd;
  assign bus.proc2mem_addr    = r_mem_addr;
  assign bus.proc2mem_data    = r_mem_data;
  assign bus.miss_count       = r_miss_count;
  assign bus.wb_count         = r_wb_count;

  // Miss FSM; the bus command/address/data are set up on the transition into
  // each request state so they come straight from flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_miss_addr    <= '0;
      r_fill_data    <= '0;
      r_tag          <= '0;
      r_cmd          <= c_BUS_NONE;
      r_mem_addr     <= '0;
      r_mem_data     <= '0;
      r_ld_rsp_valid <= 1'b0;
      r_ld_rsp_data  <= '0;
      r_miss_count   <= '0;
      r_wb_count     <= '0;
    end else begin
      r_ld_rsp_valid <= w_ld_accept;
      if (w_ld_accept) begin
        r_ld_rsp_data <= bus.rd1_data_out;
      end

      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_miss_addr <= w_miss_addr;
            if (r_miss_count != {CNT_W{1'b1}}) begin
              r_miss_count <= r_miss_count + CNT_W'(1);
            end
            if (bus.evicted_valid_out & bus.evicted_dirty_out) begin
              r_state    <= WB_REQ;
              r_cmd      <= c_BUS_STORE;
              r_mem_addr <= line_align(bus.evicted_addr_out);
              r_mem_data <= bus.evicted_data_out;
            end else begin
              r_state    <= FILL_REQ;
              r_cmd      <= c_BUS_LOAD;
              r_mem_addr <= line_align(w_miss_addr);
              r_mem_data <= '0;
            end
          end
        end
        WB_REQ: begin
          if (bus.mem2proc_response != '0) begin
            if (r_wb_count != {CNT_W{1'b1}}) begin
              r_wb_count <= r_wb_count + CNT_W'(1);
            end
            r_state    <= FILL_REQ;
            r_cmd      <= c_BUS_LOAD;
            r_mem_addr <= line_align(r_miss_addr);
            r_mem_data <= '0;
          end
        end
        FILL_REQ: begin
          if (bus.mem2proc_response != '0) begin
            r_tag   <= bus.mem2proc_response;
            r_state <= FILL_WAIT;
            r_cmd   <= c_BUS_NONE;
          end
        end
        FILL_WAIT: begin
          if (w_tag_match) begin
            r_fill_data <= bus.mem2proc_data;
            r_tag       <= '0;
            r_state     <= FILL_WRITE;
          end
        end
        FILL_WRITE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cmd   <= c_BUS_NONE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl. Table of single-cycle
//               hit vectors plus directed miss, writeback, rejection, reset
//               and counter-saturation sequences. The array and memory are
//               played by the bench directly. Counters are 4 bits wide here.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

  localparam logic [1:0] c_NONE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_STORE = 2'd2;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  dcache_ctrl_if #(.MEM_TAG_W(4), .CNT_W(4)) ifc ();

  dcache_ctrl #(.MEM_TAG_W(4), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        ld_v;
    logic [63:0] ld_a;
    logic        rd_hit;
    logic [63:0] rd_data;
    logic        st_v;
    logic [63:0] st_a;
    logic [63:0] st_d;
    logic        wr_hit;
    logic        e_ld_rdy;
    logic        e_st_rdy;
    logic        e_wr_en;
    logic        e_wr_search;
    logic [63:0] e_wr_addr;
    logic        e_rsp_v;
    logic [63:0] e_rsp_d;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.ld_req_valid      = 1'b0;
    ifc.ld_req_addr       = '0;
    ifc.st_req_valid      = 1'b0;
    ifc.st_req_addr       = '0;
    ifc.st_req_data       = '0;
    ifc.rd1_hit_out       = 1'b0;
    ifc.rd1_data_out      = '0;
    ifc.wr1_hit_out       = 1'b0;
    ifc.evicted_valid_out = 1'b0;
    ifc.evicted_dirty_out = 1'b0;
    ifc.evicted_addr_out  = '0;
    ifc.evicted_data_out  = '0;
    ifc.mem2proc_response = '0;
    ifc.mem2proc_tag      = '0;
    ifc.mem2proc_data     = '0;
  endtask

  // Clean-victim load miss that completes with tag 1; the load is dropped
  // during the fill so the controller simply returns to IDLE.
  task automatic quick_miss(input logic [63:0] a);
    tick();
    ifc.ld_req_valid = 1'b1;
    ifc.ld_req_addr  = a;
    ifc.rd1_hit_out  = 1'b0;
    tick();
    ifc.mem2proc_response = 4'd1;
    tick();
    ifc.mem2proc_response = 4'd0;
    ifc.mem2proc_tag      = 4'd1;
    ifc.mem2proc_data     = a;
    tick();
    ifc.mem2proc_tag = 4'd0;
    ifc.ld_req_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();

    //                ld_v  ld_a        hit   rd_data       st_v  st_a        st_d          wr_hit ldr   str   en    srch  wr_addr     rsp   rsp_d
    vecs[0] = '{1'b0, 64'h0,    1'b0, 64'h0,      1'b0, 64'h0,    64'h0,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 64'h0};
    vecs[1] = '{1'b1, 64'h100,  1'b1, 64'h1234,   1'b0, 64'h0,    64'h0,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h100,  1'b1, 64'h1234};
    vecs[2] = '{1'b0, 64'h0,    1'b0, 64'h0,      1'b1, 64'h208,  64'hBEEF,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h208,  1'b0, 64'h0};
    vecs[3] = '{1'b1, 64'h100,  1'b1, 64'h4444,   1'b1, 64'h208,  64'hCAFE,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h208,  1'b1, 64'h4444};
    vecs[4] = '{1'b1, 64'h40,   1'b1, 64'h9999,   1'b1, 64'h44,   64'h7070,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h44,   1'b0, 64'h0};
    vecs[5] = '{1'b1, 64'h500,  1'b0, 64'h0,      1'b1, 64'h600,  64'h6060,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h600,  1'b0, 64'h0};

    // ---------------- reset state ----------------
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_ld_ready", ifc.ld_req_ready, 1'b0);
    chk("rst_st_ready", ifc.st_req_ready, 1'b0);
    chk("rst_rsp_valid", ifc.ld_rsp_valid, 1'b0);
    chk("rst_rsp_data", ifc.ld_rsp_data, 64'h0);
    chk("rst_cmd", ifc.proc2mem_command, c_NONE);
    chk("rst_wr1_en", ifc.wr1_en, 1'b0);
    chk("rst_miss_count", ifc.miss_count, 4'd0);
    chk("rst_wb_count", ifc.wb_count, 4'd0);

    // ---------------- table-driven hit vectors ----------------
    for (int i = 0; i < 6; i++) begin
      tick();
      ifc.ld_req_valid = vecs[i].ld_v;
      ifc.ld_req_addr  = vecs[i].ld_a;
      ifc.rd1_hit_out  = vecs[i].rd_hit;
      ifc.rd1_data_out = vecs[i].rd_data;
      ifc.st_req_valid = vecs[i].st_v;
      ifc.st_req_addr  = vecs[i].st_a;
      ifc.st_req_data  = vecs[i].st_d;
      ifc.wr1_hit_out  = vecs[i].wr_hit;
      #1;
      chk($sformatf("v%0d_ld_ready", i), ifc.ld_req_ready, vecs[i].e_ld_rdy);
      chk($sformatf("v%0d_st_ready", i), ifc.st_req_ready, vecs[i].e_st_rdy);
      chk($sformatf("v%0d_wr1_en", i), ifc.wr1_en, vecs[i].e_wr_en);
      chk($sformatf("v%0d_wr1_dirty", i), ifc.wr1_dirty, vecs[i].e_wr_en);
      chk($sformatf("v%0d_wr1_search", i), ifc.wr1_search, vecs[i].e_wr_search);
      chk($sformatf("v%0d_wr1_addr", i), ifc.wr1_addr, vecs[i].e_wr_addr);
      chk($sformatf("v%0d_wr1_from_mem", i), ifc.wr1_from_mem, 1'b0);
      if (vecs[i].e_wr_en) chk($sformatf("v%0d_wr1_data", i), ifc.wr1_data, vecs[i].st_d);
      tick();
      chk($sformatf("v%0d_rsp_valid", i), ifc.ld_rsp_valid, vecs[i].e_rsp_v);
      if (vecs[i].e_rsp_v) chk($sformatf("v%0d_rsp_data", i), ifc.ld_rsp_data, vecs[i].e_rsp_d);
      chk($sformatf("v%0d_cmd", i), ifc.proc2mem_command, c_NONE);
      clear_inputs();
    end

    // ---------------- load miss, clean victim ----------------
    tick();
    ifc.ld_req_valid = 1'b1;
    ifc.ld_req_addr  = 64'h1000;
    #1;
    chk("lm_wr1_search", ifc.wr1_search, 1'b1);
    chk("lm_wr1_addr", ifc.wr1_addr, 64'h1000);
    chk("lm_ld_ready", ifc.ld_req_ready, 1'b0);
    tick();
    chk("lm_cmd_load", ifc.proc2mem_command, c_LOAD);
    chk("lm_addr", ifc.proc2mem_addr, 64'h1000);
    ifc.mem2proc_response = 4'd5;
    tick();
    ifc.mem2proc_response = 4'd0;
    chk("lm_cmd_none", ifc.proc2mem_command, c_NONE);
    ifc.mem2proc_tag  = 4'd5;
    ifc.mem2proc_data = 64'hAAAA;
    tick();
    ifc.mem2proc_tag = 4'd0;
    chk("lm_fw_en", ifc.wr1_en, 1'b1);
    chk("lm_fw_from_mem", ifc.wr1_from_mem, 1'b1);
    chk("lm_fw_dirty", ifc.wr1_dirty, 1'b0);
    chk("lm_fw_valid", ifc.wr1_valid, 1'b1);
    chk("lm_fw_data", ifc.wr1_data, 64'hAAAA);
    chk("lm_fw_addr", ifc.wr1_addr, 64'h1000);
    ifc.rd1_hit_out  = 1'b1;
    ifc.rd1_data_out = 64'hAAAA;
    #1;
    chk("lm_fw_no_ready", ifc.ld_req_ready, 1'b0);
    tick();
    chk("lm_retry_ready", ifc.ld_req_ready, 1'b1);
    chk("lm_retry_no_wr", ifc.wr1_en, 1'b0);
    tick();
    clear_inputs();
    chk("lm_rsp_valid", ifc.ld_rsp_valid, 1'b1);
    chk("lm_rsp_data", ifc.ld_rsp_data, 64'hAAAA);
    chk("lm_miss_count", ifc.miss_count, 4'd1);
    chk("lm_wb_count", ifc.wb_count, 4'd0);

    // ---------------- store miss, dirty victim ----------------
    tick();
    ifc.st_req_valid      = 1'b1;
    ifc.st_req_addr       = 64'h2008;
    ifc.st_req_data       = 64'h99;
    ifc.evicted_valid_out = 1'b1;
    ifc.evicted_dirty_out = 1'b1;
    ifc.evicted_addr_out  = 64'h3008;
    ifc.evicted_data_out  = 64'h55;
    #1;
    chk("sm_wr1_addr", ifc.wr1_addr, 64'h2008);
    chk("sm_st_ready", ifc.st_req_ready, 1'b0);
    chk("sm_no_wr", ifc.wr1_en, 1'b0);
    tick();
    ifc.evicted_valid_out = 1'b0;
    ifc.evicted_dirty_out = 1'b0;
    chk("sm_cmd_store", ifc.proc2mem_command, c_STORE);
    chk("sm_wb_addr", ifc.proc2mem_addr, 64'h3008);
    chk("sm_wb_data", ifc.proc2mem_data, 64'h55);
    tick();
    chk("sm_wb_held", ifc.proc2mem_command, c_STORE);
    ifc.mem2proc_response = 4'd7;
    tick();
    chk("sm_cmd_load", ifc.proc2mem_command, c_LOAD);
    chk("sm_fill_addr", ifc.proc2mem_addr, 64'h2008);
    chk("sm_wb_count", ifc.wb_count, 4'd1);
    ifc.mem2proc_response = 4'd4;
    tick();
    ifc.mem2proc_response = 4'd0;
    ifc.mem2proc_tag      = 4'd4;
    ifc.mem2proc_data     = 64'h1111;
    tick();
    ifc.mem2proc_tag = 4'd0;
    chk("sm_fw_en", ifc.wr1_en, 1'b1);
    chk("sm_fw_addr", ifc.wr1_addr, 64'h2008);
    chk("sm_fw_data", ifc.wr1_data, 64'h1111);
    chk("sm_fw_no_ready", ifc.st_req_ready, 1'b0);
    ifc.wr1_hit_out = 1'b1;
    tick();
    chk("sm_retry_ready", ifc.st_req_ready, 1'b1);
    chk("sm_retry_en", ifc.wr1_en, 1'b1);
    chk("sm_retry_dirty", ifc.wr1_dirty, 1'b1);
    chk("sm_retry_from_mem", ifc.wr1_from_mem, 1'b0);
    chk("sm_retry_data", ifc.wr1_data, 64'h99);
    tick();
    clear_inputs();
    chk("sm_miss_count", ifc.miss_count, 4'd2);

    // ---------------- same-line load and store hit ----------------
    tick();
    ifc.ld_req_valid = 1'b1;
    ifc.ld_req_addr  = 64'h40;
    ifc.rd1_hit_out  = 1'b1;
    ifc.rd1_data_out = 64'h12;
    ifc.st_req_valid = 1'b1;
    ifc.st_req_addr  = 64'h40;
    ifc.st_req_data  = 64'h77;
    ifc.wr1_hit_out  = 1'b1;
    #1;
    chk("sl_st_ready_n", ifc.st_req_ready, 1'b1);
    chk("sl_ld_ready_n", ifc.ld_req_ready, 1'b0);
    tick();
    ifc.st_req_valid = 1'b0;
    ifc.wr1_hit_out  = 1'b0;
    ifc.rd1_data_out = 64'h77;
    #1;
    chk("sl_ld_ready_n1", ifc.ld_req_ready, 1'b1);
    chk("sl_rsp_not_yet", ifc.ld_rsp_valid, 1'b0);
    tick();
    clear_inputs();
    chk("sl_rsp_valid", ifc.ld_rsp_valid, 1'b1);
    chk("sl_rsp_data", ifc.ld_rsp_data, 64'h77);

    // ---------------- memory rejection, foreign tag ----------------
    tick();
    ifc.ld_req_valid = 1'b1;
    ifc.ld_req_addr  = 64'h4000;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rj_cmd_load_%0d", i), ifc.proc2mem_command, c_LOAD);
      ifc.mem2proc_response = (i == 3) ? 4'd2 : 4'd0;
      tick();
    end
    ifc.mem2proc_response = 4'd0;
    chk("rj_cmd_none", ifc.proc2mem_command, c_NONE);
    ifc.mem2proc_tag  = 4'd1;
    ifc.mem2proc_data = 64'hBAD;
    tick();
    chk("rj_tag1_ignored", ifc.wr1_en, 1'b0);
    ifc.mem2proc_tag  = 4'd2;
    ifc.mem2proc_data = 64'hC0DE;
    tick();
    ifc.mem2proc_tag = 4'd0;
    ifc.ld_req_valid = 1'b0;
    chk("rj_fw_en", ifc.wr1_en, 1'b1);
    chk("rj_fw_data", ifc.wr1_data, 64'hC0DE);
    tick();
    chk("rj_back_idle", ifc.wr1_en, 1'b0);
    chk("rj_miss_count", ifc.miss_count, 4'd3);
    chk("rj_wb_count", ifc.wb_count, 4'd1);
    clear_inputs();

    // ---------------- async reset during FILL_WAIT ----------------
    tick();
    ifc.ld_req_valid = 1'b1;
    ifc.ld_req_addr  = 64'h5000;
    tick();
    ifc.mem2proc_response = 4'd3;
    tick();
    ifc.mem2proc_response = 4'd0;
    reset = 1'b1;
    #1;
    chk("ar_miss_count", ifc.miss_count, 4'd0);
    chk("ar_wb_count", ifc.wb_count, 4'd0);
    chk("ar_cmd", ifc.proc2mem_command, c_NONE);
    ifc.ld_req_valid = 1'b0;
    tick();
    reset = 1'b0;
    ifc.mem2proc_tag  = 4'd3;
    ifc.mem2proc_data = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ar_no_wr_%0d", i), ifc.wr1_en, 1'b0);
    end
    ifc.mem2proc_tag = 4'd0;
    ifc.ld_req_valid = 1'b1;
    ifc.ld_req_addr  = 64'h80;
    ifc.rd1_hit_out  = 1'b1;
    #1;
    chk("ar_idle_ready", ifc.ld_req_ready, 1'b1);
    tick();
    clear_inputs();
    chk("ar_miss_count_after", ifc.miss_count, 4'd0);

    // ---------------- miss counter saturation ----------------
    for (int k = 1; k <= 15; k++) quick_miss(64'h8000 + 64'(k * 8));
    chk("sat_count_15", ifc.miss_count, 4'd15);
    quick_miss(64'h9000);
    chk("sat_count_hold", ifc.miss_count, 4'd15);
    chk("sat_wb_zero", ifc.wb_count, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
